grid_map_server: RTL and testbench
==================================

# grid_map_server

Responder side of the maze-grid read handshake. The server accepts word-address read requests from up to `NUM_REQ` grid clients, such as player movement control and the ray-casting DDA. It arbitrates them round-robin onto one shared single-port map BRAM, pipelining one BRAM read per cycle. Each result goes back to its originating client as a one-cycle valid pulse. The block sits between the clients and the map memory holding four stacked `N`×`N` maps.

## Interface
Parameters:
- `N`, 24: grid side length; a map occupies `N*N` cells.
- `NUM_REQ`, 2: number of client ports.
- `BRAM_LATENCY`, 2: cycles from `bram_addr` presentation to `bram_dout` valid.
- `NUM_MAPS`, 4: number of stacked maps.

Ports:
- `clk_in`  in  1  system clock; one clock domain.
- `rst_in`  in  1  reset; synchronous, active-high.
- `grid_req`  in  `NUM_REQ`  per-client request level; held high with a stable address until that client's valid.
- `grid_addr`  in  `NUM_REQ`×`$clog2(N*N)`  per-client cell address, `x + N*y`.
- `grid_valid`  out  `NUM_REQ`  per-client one-cycle response strobe.
- `grid_data`  out  4  response cell value; shared bus, qualified by `grid_valid`.
- `map_select`  in  `$clog2(NUM_MAPS)`  active map.
- `bram_addr`  out  `$clog2(NUM_MAPS*N*N)`  registered BRAM address.
- `bram_dout`  in  4  BRAM read data.

## Operation
- Eligibility: client i is eligible when all three hold:
  - `grid_req[i]`=1;
  - `pending[i]`=0, meaning no read is in flight for it;
  - `armed[i]`=1.
- Arming: `armed[i]` clears on client i's response cycle. It sets again only after `grid_req[i]` has been sampled 0. This prevents re-serving a client that drops its request one cycle after valid.
- Arbitration: each cycle, at most one eligible client is granted.
  - The round-robin pointer starts at the client after the last grantee.
  - After reset, client 0 has top priority.
- On grant:
  - `pending[i]` is set.
  - `bram_addr` is set to `map_select*N*N + grid_addr[i]`.
  - `map_select` is sampled at grant, so later changes do not affect in-flight reads.
- Out of range: when `grid_addr[i] >= N*N`, `bram_addr` is driven 0 and an OOB flag travels with the tag. The response returns 4'hF (wall) at normal latency.
- Tag pipeline: a shift register `BRAM_LATENCY+1` deep carries {valid, client index, oob}.
- Response stage: on exit from the pipeline, the block registers:
  - `grid_data` = oob ? 4'hF : `bram_dout`;
  - `grid_valid[idx]` = 1;
  - `pending[idx]` cleared, `armed[idx]` cleared.
- Exclusivity: at most one bit of `grid_valid` is high in any cycle.
- Request withdrawn: if a client drops `grid_req` while its read is pending, the response is still delivered.
- Arithmetic: address arithmetic is unsigned, and the sum fits `bram_addr` width exactly.

## Timing
- Latency: a request first high in cycle t with no contention gives `bram_addr` valid in t+1 and `grid_valid` in t+2+`BRAM_LATENCY` (t+4 at default).
- Throughput: one grant per cycle across clients, and one outstanding read per client.
- Reset values:
  - `grid_valid`=0, `grid_data`=0, `bram_addr`=0;
  - all pending and pipeline-valid bits=0, all `armed`=1, RR pointer=0.
- Reset mid-operation: in-flight reads are discarded and no valid is emitted for them. A request still high after reset is re-served from scratch.
- Simultaneous events are all allowed in the same cycle: a response on client i, a grant to client j≠i, and `grid_req[i]` falling.

## Structure
- Shared package `grid_pkg`:
  - `CELL_W`=4 and `WALL_OOB`=4'hF;
  - address-width helper constants;
  - the tag struct typedef {valid, idx, oob}.
- Sub-module `rr_arbiter`, parameterized by `NUM_REQ`: takes the eligible vector and outputs a one-hot grant plus the pointer update.
- BRAM stays external; the bench supplies a behavioural model with `BRAM_LATENCY` cycles.

## Test plan
- Single client: client 0 requests addr 25 on map 0, with the BRAM holding 3 there. Expect `bram_addr`=25 at t+1, `grid_valid`=01 with data 3 at t+4, and no repeat while req falls at t+5.
- Contention: both clients assert in cycle t, addresses 10 and 20. Client 0 is granted at t and valid at t+4; client 1 is granted at t+1 and valid at t+5. The next simultaneous pair grants client 1 first.
- Map offset: `map_select`=2, addr 5 gives `bram_addr`=1157. Changing `map_select` to 0 the cycle after grant does not alter the returned data.
- Out of range: addr 600 gives no nonzero `bram_addr`, and valid at t+4 carries 4'hF.
- Held request: client holds req high for 3 cycles after valid. There is no second response until req has been sampled low and re-asserted.
- Mid-flight reset: `rst_in` pulses at t+2 of an outstanding read. No `grid_valid` occurs, all outputs are 0, and a re-asserted req is served with nominal latency.

Source files
------------

// File: rtl/grid_map_server_pkg.sv
// grid_pkg: shared types and constants for the maze-grid read server.
//   CELL_W / WALL_OOB : cell width and the value returned for off-map reads
//   idx_w / cell_aw / bram_aw : address-width helpers (never narrower than 1 bit)
//   tag_t : {valid, client index, oob} carried alongside each BRAM read
package grid_pkg;

    localparam int                CELL_W    = 4;
    localparam logic [CELL_W-1:0] WALL_OOB  = 4'hF;
    // Tag index field is fixed-width so the struct can live here; this caps
    // the server at 16 clients.
    localparam int                TAG_IDX_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cell_aw(input int n);
        return idx_w(n * n);
    endfunction

    function automatic int bram_aw(input int n, input int maps);
        return idx_w(maps * n * n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
        logic                 oob;
    } tag_t;

endpackage

// File: rtl/grid_map_server_if.sv
// grid_map_server_if: client-side request/response bundle of the grid server.
//   grid_req   : per-client request level (held until that client's valid)
//   grid_addr  : per-client cell address x + N*y
//   grid_valid : per-client one-cycle response strobe
//   grid_data  : shared response cell value, qualified by grid_valid
//   map_select : active map, sampled at grant
// master = clients, slave = server.
interface grid_map_server_if
    import grid_pkg::*;
#(
    parameter int N        = 24,
    parameter int NUM_REQ  = 2,
    parameter int NUM_MAPS = 4
);
    logic [NUM_REQ-1:0]                 grid_req;
    logic [NUM_REQ-1:0][cell_aw(N)-1:0] grid_addr;
    logic [NUM_REQ-1:0]                 grid_valid;
    logic [CELL_W-1:0]                  grid_data;
    logic [idx_w(NUM_MAPS)-1:0]         map_select;

    modport master (output grid_req, grid_addr, map_select,
                    input  grid_valid, grid_data);
    modport slave  (input  grid_req, grid_addr, map_select,
                    output grid_valid, grid_data);
endinterface

// File: rtl/grid_map_server_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NUM_REQ eligible clients.
//   elig      : eligible vector
//   ptr       : current top-priority client
//   grant     : one-hot grant (all zero when nothing eligible)
//   grant_idx : index of the granted client
//   grant_vld : any grant this cycle
//   ptr_nxt   : client after the grantee (equals ptr when no grant)
module rr_arbiter
    import grid_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        elig,
    input  logic [idx_w(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [idx_w(NUM_REQ)-1:0] grant_idx,
    output logic                      grant_vld,
    output logic [idx_w(NUM_REQ)-1:0] ptr_nxt
);
    localparam int IDX_W = idx_w(NUM_REQ);

    int cand;

    // Scan starting at ptr, wrapping; the first eligible client wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        ptr_nxt   = ptr;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_vld && elig[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                ptr_nxt     = IDX_W'((cand + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/grid_map_server.sv
// grid_map_server: round-robin read server in front of a shared single-port
// map BRAM holding NUM_MAPS stacked N x N maps. One BRAM read issued per
// cycle; each result returns to its client as a one-cycle grid_valid pulse.
//   clk_in, rst_in : clock, synchronous active-high reset
//   gif (slave)    : client request/response bundle
//   bram_addr      : registered BRAM read address
//   bram_dout      : BRAM read data, BRAM_LATENCY cycles after bram_addr
module grid_map_server
    import grid_pkg::*;
#(
    parameter int N            = 24,
    parameter int NUM_REQ      = 2,
    parameter int BRAM_LATENCY = 2,
    parameter int NUM_MAPS     = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    grid_map_server_if.slave                gif,
    output logic [bram_aw(N, NUM_MAPS)-1:0] bram_addr,
    input  logic [CELL_W-1:0]               bram_dout
);
    localparam int AW    = cell_aw(N);
    localparam int BAW   = bram_aw(N, NUM_MAPS);
    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CELLS = N * N;

    logic [NUM_REQ-1:0] pending;   // read in flight for the client
    logic [NUM_REQ-1:0] armed;     // client has dropped req since its last response
    logic [NUM_REQ-1:0] elig, grant, resp_hot;
    logic [IDX_W-1:0]   rr_ptr, ptr_nxt, gnt_idx;
    logic               gnt_vld, gnt_oob;
    logic [AW-1:0]      gnt_addr;
    logic [BAW-1:0]     gnt_baddr;

    // Stage s holds the tag of the read presented to the BRAM s cycles ago;
    // the last stage lines up with bram_dout.
    tag_t vld_pipe [BRAM_LATENCY:0];
    tag_t tag_out;

    assign elig = gif.grid_req & ~pending & armed;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .elig      (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld),
        .ptr_nxt   (ptr_nxt)
    );

    assign gnt_addr  = gif.grid_addr[gnt_idx];
    assign gnt_oob   = 32'(gnt_addr) >= 32'(CELLS);
    // Off-map reads still go to the BRAM (at address 0) so the response keeps
    // the normal latency; the data is replaced at the response stage.
    assign gnt_baddr = gnt_oob ? '0
                     : BAW'(gif.map_select) * BAW'(CELLS) + BAW'(gnt_addr);

    assign tag_out = vld_pipe[BRAM_LATENCY];

    always_comb begin
        resp_hot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            resp_hot[i] = tag_out.valid && (tag_out.idx == TAG_IDX_W'(i));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending        <= '0;
            armed          <= '1;
            rr_ptr         <= '0;
            bram_addr      <= '0;
            gif.grid_valid <= '0;
            gif.grid_data  <= '0;
            for (int s = 0; s <= BRAM_LATENCY; s++)
                vld_pipe[s] <= '0;
        end else begin
            vld_pipe[0] <= '{valid: gnt_vld, idx: TAG_IDX_W'(gnt_idx), oob: gnt_oob};
            for (int s = 1; s <= BRAM_LATENCY; s++)
                vld_pipe[s] <= vld_pipe[s-1];

            if (gnt_vld) begin
                bram_addr <= gnt_baddr;
                rr_ptr    <= ptr_nxt;
            end

            gif.grid_valid <= resp_hot;
            if (tag_out.valid)
                gif.grid_data <= tag_out.oob ? WALL_OOB : bram_dout;

            // Grant and response never hit the same client in one cycle:
            // a grant needs pending=0, a response implies pending=1.
            pending <= (pending & ~resp_hot) | grant;
            // Re-arm only once req is seen low, so a client that keeps req
            // high for a cycle or more after its valid is not served twice.
            armed   <= (armed | ~gif.grid_req) & ~resp_hot;
        end
    end

endmodule

// File: tb/tb_grid_map_server.sv
// Directed scenarios followed by a randomized multi-client phase, checked
// against a map-memory reference and per-client request bookkeeping.
module tb_grid_map_server;
    localparam int N        = 24;
    localparam int NUM_REQ  = 2;
    localparam int LAT      = 2;
    localparam int NUM_MAPS = 4;
    localparam int CELLS    = N * N;

    logic        clk_in;
    logic        rst_in;
    logic [11:0] bram_addr;
    logic [3:0]  bram_dout;

    grid_map_server_if #(.N(N), .NUM_REQ(NUM_REQ), .NUM_MAPS(NUM_MAPS)) gif ();

    grid_map_server #(.N(N), .NUM_REQ(NUM_REQ), .BRAM_LATENCY(LAT), .NUM_MAPS(NUM_MAPS)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .gif       (gif),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural BRAM: data for an address appears LAT cycles after it.
    logic [3:0] mem   [0:NUM_MAPS*CELLS-1];
    logic [3:0] dpipe [LAT];
    always @(posedge clk_in) begin
        dpipe[0] <= mem[bram_addr];
        for (int s = 1; s < LAT; s++) dpipe[s] <= dpipe[s-1];
    end
    assign bram_dout = dpipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            chk(tag, gif.grid_valid, 0);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    // Uncontended read: req high from cycle t, valid expected at t+4,
    // req held through t+4 and dropped at t+5.
    task automatic single(input int i, input int addr, input int map, input int map_after,
                          input int exp_ba, input logic [3:0] exp_d, input string tag);
        gif.map_select   = 2'(map);
        gif.grid_addr[i] = 10'(addr);
        gif.grid_req[i]  = 1'b1;
        step();
        chk({tag, "_baddr"}, bram_addr, exp_ba);
        chk({tag, "_early"}, gif.grid_valid, 0);
        gif.map_select = 2'(map_after);
        quiet(2, {tag, "_early"});
        step();
        chk({tag, "_valid"}, gif.grid_valid, 1 << i);
        chk({tag, "_data"}, gif.grid_data, exp_d);
        step();
        chk({tag, "_norepeat"}, gif.grid_valid, 0);
        gif.grid_req[i] = 1'b0;
        quiet(1, {tag, "_norepeat"});
    endtask

    int         st   [NUM_REQ];   // 0 idle (req low), 1 waiting, 2 holding req after valid
    int         hold [NUM_REQ];
    int         t0   [NUM_REQ];
    logic [3:0] expd [NUM_REQ];
    int         lat, a, busy_any;

    initial begin
        for (int k = 0; k < NUM_MAPS * CELLS; k++) mem[k] = 4'($urandom);
        mem[25] = 4'h3; mem[5] = 4'h6; mem[1157] = 4'h9; mem[0] = 4'h2;
        mem[7]  = 4'h5; mem[30] = 4'hA;

        rst_in = 1'b1; gif.grid_req = '0; gif.grid_addr = '0; gif.map_select = '0;
        step(); step();
        chk("rst_valid", gif.grid_valid, 0);
        chk("rst_data", gif.grid_data, 0);
        chk("rst_baddr", bram_addr, 0);
        rst_in = 1'b0;

        single(0, 25, 0, 0, 25, 4'h3, "single");

        // Contention: fresh reset puts client 0 first.
        do_reset();
        gif.map_select = '0;
        gif.grid_addr[0] = 10'd10; gif.grid_addr[1] = 10'd20; gif.grid_req = 2'b11;
        step(); chk("cont_baddr0", bram_addr, 10);
        step(); chk("cont_baddr1", bram_addr, 20); chk("cont_early", gif.grid_valid, 0);
        quiet(1, "cont_early");
        step(); chk("cont_valid0", gif.grid_valid, 1); chk("cont_data0", gif.grid_data, mem[10]);
        step(); chk("cont_valid1", gif.grid_valid, 2); chk("cont_data1", gif.grid_data, mem[20]);
        gif.grid_req = 2'b00;
        quiet(1, "cont_idle");

        // Client 0 served last, so the next simultaneous pair favours client 1.
        single(0, 11, 0, 0, 11, mem[11], "rr_pre");
        gif.grid_addr[0] = 10'd12; gif.grid_addr[1] = 10'd13; gif.grid_req = 2'b11;
        step(); chk("rr_baddr1", bram_addr, 13);
        step(); chk("rr_baddr0", bram_addr, 12);
        quiet(1, "rr_early");
        step(); chk("rr_valid1", gif.grid_valid, 2); chk("rr_data1", gif.grid_data, mem[13]);
        step(); chk("rr_valid0", gif.grid_valid, 1); chk("rr_data0", gif.grid_data, mem[12]);
        gif.grid_req = 2'b00;
        quiet(1, "rr_idle");

        single(0, 5, 2, 0, 1157, 4'h9, "map");
        single(1, 600, 0, 0, 0, 4'hF, "oob");

        // Held request: req stays high 3 cycles past valid, then re-asserts.
        gif.grid_addr[0] = 10'd7; gif.grid_req[0] = 1'b1;
        quiet(3, "held_early");
        step(); chk("held_valid", gif.grid_valid, 1); chk("held_data", gif.grid_data, 4'h5);
        quiet(4, "held_norepeat");
        gif.grid_req[0] = 1'b0;
        quiet(1, "held_low");
        gif.grid_req[0] = 1'b1;
        quiet(3, "held2_early");
        step(); chk("held2_valid", gif.grid_valid, 1); chk("held2_data", gif.grid_data, 4'h5);
        gif.grid_req[0] = 1'b0;
        quiet(1, "held2_idle");

        // Reset pulse while a read is in flight.
        gif.grid_addr[0] = 10'd30; gif.grid_req[0] = 1'b1;
        step();
        step(); rst_in = 1'b1; gif.grid_req[0] = 1'b0;
        step(); rst_in = 1'b0;
        chk("mrst_valid", gif.grid_valid, 0);
        chk("mrst_data", gif.grid_data, 0);
        chk("mrst_baddr", bram_addr, 0);
        quiet(1, "mrst_drop");
        gif.grid_req[0] = 1'b1;
        quiet(3, "mrst_drop");
        step(); chk("mrst_valid2", gif.grid_valid, 1); chk("mrst_data2", gif.grid_data, 4'hA);
        gif.grid_req[0] = 1'b0;
        quiet(1, "mrst_idle");

        // Randomized phase: any request is answered within 4..5 cycles
        // (at most one round-robin loss with two clients) with the cell of
        // the map selected when it was raised.
        for (int i = 0; i < NUM_REQ; i++) begin st[i] = 0; hold[i] = 0; t0[i] = 0; expd[i] = '0; end
        for (int n = 0; n < 400; n++) begin
            step();
            chk("rnd_onehot0", 32'($onehot0(gif.grid_valid)), 1);
            busy_any = 0;
            for (int i = 0; i < NUM_REQ; i++) if (st[i] == 1) busy_any = 1;
            if (busy_any == 0 && $urandom_range(0, 7) == 0) gif.map_select = 2'($urandom_range(0, 3));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (st[i] == 1) begin
                    lat = cyc - t0[i];
                    if (gif.grid_valid[i] || lat >= 5) begin
                        chk("rnd_valid_deadline", gif.grid_valid[i], 1);
                        if (gif.grid_valid[i]) begin
                            chk("rnd_data", gif.grid_data, expd[i]);
                            chk("rnd_latency_min", 32'(lat >= 4), 1);
                        end
                        st[i] = 2; hold[i] = $urandom_range(0, 2);
                    end
                end else begin
                    chk("rnd_spurious", gif.grid_valid[i], 0);
                    if (st[i] == 2) begin
                        if (hold[i] == 0) begin gif.grid_req[i] = 1'b0; st[i] = 0; end
                        else hold[i]--;
                    end else if (n < 380 && $urandom_range(0, 1) == 1) begin
                        a = $urandom_range(0, 640);
                        gif.grid_addr[i] = 10'(a);
                        gif.grid_req[i]  = 1'b1;
                        expd[i] = (a >= CELLS) ? 4'hF : mem[int'(gif.map_select) * CELLS + a];
                        t0[i] = cyc; st[i] = 1;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
